// File: rtl/axi3_ocm_slave.sv
// AXI3 INCR-burst slave in front of a word-wide on-chip memory.
// Write and read channels are independent, each with at most one burst in flight.
module axi3_ocm_slave #(
   parameter logic [31:0] base_addr = 32'hfffc0000,
   parameter int          mem_width = 10
) (
   input  logic        AXI_clk,
   input  logic        rst,
   input  logic [31:0] AXI_awaddr,
   input  logic [5:0]  AXI_awid,
   input  logic [3:0]  AXI_awlen,
   input  logic [2:0]  AXI_awsize,
   input  logic [1:0]  AXI_awburst,
   input  logic        AXI_awvalid,
   output logic        AXI_awready,
   input  logic [31:0] AXI_wdata,
   input  logic [3:0]  AXI_wstrb,
   input  logic        AXI_wlast,
   input  logic        AXI_wvalid,
   output logic        AXI_wready,
   output logic [5:0]  AXI_bid,
   output logic [1:0]  AXI_bresp,
   output logic        AXI_bvalid,
   input  logic        AXI_bready,
   input  logic [31:0] AXI_araddr,
   input  logic [5:0]  AXI_arid,
   input  logic [3:0]  AXI_arlen,
   input  logic [2:0]  AXI_arsize,
   input  logic [1:0]  AXI_arburst,
   input  logic        AXI_arvalid,
   output logic        AXI_arready,
   output logic [31:0] AXI_rdata,
   output logic [5:0]  AXI_rid,
   output logic [1:0]  AXI_rresp,
   output logic        AXI_rlast,
   output logic        AXI_rvalid,
   input  logic        AXI_rready
);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [31:0] r_mem [2**mem_width];

   w_state_t    r_wstate, w_wnext;
   r_state_t    r_rstate, w_rnext;
   logic        r_awready, r_wready, r_bvalid, r_werr;
   logic [1:0]  r_bresp;
   logic [5:0]  r_bid;
   logic [31:0] r_waddr;
   logic [3:0]  r_wlen, r_wcnt;
   logic        r_arready, r_rvalid, r_rlast;
   logic [31:0] r_rdata, r_raddr;
   logic [1:0]  r_rresp;
   logic [5:0]  r_rid;
   logic [3:0]  r_rlen, r_rcnt;

   logic        w_wbeat, w_wlast_beat, w_win, w_werr_nxt;
   logic        w_aw_hs, w_ar_hs, w_rbeat;
   logic [31:0] w_raddr_ld, w_rword;
   logic        w_rin;
   logic        w_unused;

   // Size and burst type are fixed on these links; the fields are ignored.
   assign w_unused = ^{AXI_awsize, AXI_awburst, AXI_arsize, AXI_arburst};

   function automatic logic f_in_win(input logic [31:0] a);
      logic [31:0] off;
      off = a - base_addr;
      return (a >= base_addr) && ((off >> (mem_width + 2)) == 32'd0);
   endfunction

   function automatic logic [mem_width-1:0] f_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - base_addr;
      return off[mem_width+1:2];
   endfunction

   assign w_aw_hs      = AXI_awvalid && r_awready;
   assign w_wbeat      = AXI_wvalid && r_wready;
   assign w_wlast_beat = (r_wcnt == r_wlen);
   assign w_win        = f_in_win(r_waddr);
   assign w_werr_nxt   = r_werr || !w_win || (AXI_wlast != w_wlast_beat);

   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
         W_DATA:  if (w_wbeat && w_wlast_beat) w_wnext = W_RESP;
         W_RESP:  if (r_bvalid && AXI_bready) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
   end

   always_ff @(posedge AXI_clk or negedge rst) begin
      if (!rst) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         r_bid     <= 6'd0;
         r_waddr   <= 32'd0;
         r_wlen    <= 4'd0;
         r_wcnt    <= 4'd0;
         r_werr    <= 1'b0;
      end else begin
         r_wstate  <= w_wnext;
         r_awready <= (w_wnext == W_IDLE);
         r_wready  <= (w_wnext == W_DATA);
         r_bvalid  <= (w_wnext == W_RESP);
         if (r_wstate == W_IDLE && w_aw_hs) begin
            r_waddr <= AXI_awaddr;
            r_wlen  <= AXI_awlen;
            r_bid   <= AXI_awid;
            r_wcnt  <= 4'd0;
            r_werr  <= 1'b0;
         end
         if (w_wbeat) begin
            r_wcnt  <= r_wcnt + 4'd1;
            r_waddr <= r_waddr + 32'd4;
            r_werr  <= w_werr_nxt;
            if (w_wlast_beat) r_bresp <= w_werr_nxt ? 2'b10 : 2'b00;
         end
      end
   end

   // Memory is deliberately not reset so contents survive a bus reset.
   always_ff @(posedge AXI_clk) begin
      if (w_wbeat && w_win) begin
         for (int b = 0; b < 4; b++) begin
            if (AXI_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= AXI_wdata[8*b +: 8];
         end
      end
   end

   assign w_ar_hs    = AXI_arvalid && r_arready;
   assign w_rbeat    = r_rvalid && AXI_rready;
   assign w_raddr_ld = (r_rstate == R_IDLE) ? AXI_araddr : r_raddr + 32'd4;
   assign w_rin      = f_in_win(w_raddr_ld);
   assign w_rword    = w_rin ? r_mem[f_idx(w_raddr_ld)] : 32'd0;

   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
         R_DATA:  if (w_rbeat && r_rcnt == r_rlen) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_ff @(posedge AXI_clk or negedge rst) begin
      if (!rst) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= 32'd0;
         r_rresp   <= 2'b00;
         r_rid     <= 6'd0;
         r_raddr   <= 32'd0;
         r_rlen    <= 4'd0;
         r_rcnt    <= 4'd0;
      end else begin
         r_rstate  <= w_rnext;
         r_arready <= (w_rnext == R_IDLE);
         r_rvalid  <= (w_rnext == R_DATA);
         if (r_rstate == R_IDLE && w_ar_hs) begin
            r_raddr <= AXI_araddr;
            r_rlen  <= AXI_arlen;
            r_rid   <= AXI_arid;
            r_rcnt  <= 4'd0;
            r_rdata <= w_rword;
            r_rresp <= w_rin ? 2'b00 : 2'b10;
            r_rlast <= (AXI_arlen == 4'd0);
         end else if (r_rstate == R_DATA && w_rbeat) begin
            if (r_rcnt == r_rlen) begin
               r_rlast <= 1'b0;
            end else begin
               r_rcnt  <= r_rcnt + 4'd1;
               r_raddr <= r_raddr + 32'd4;
               r_rdata <= w_rword;
               r_rresp <= w_rin ? 2'b00 : 2'b10;
               r_rlast <= (4'(r_rcnt + 4'd1) == r_rlen);
            end
         end
      end
   end

   assign AXI_awready = r_awready;
   assign AXI_wready  = r_wready;
   assign AXI_bvalid  = r_bvalid;
   assign AXI_bresp   = r_bresp;
   assign AXI_bid     = r_bid;
   assign AXI_arready = r_arready;
   assign AXI_rvalid  = r_rvalid;
   assign AXI_rlast   = r_rlast;
   assign AXI_rdata   = r_rdata;
   assign AXI_rresp   = r_rresp;
   assign AXI_rid     = r_rid;
endmodule

// File: tb/tb_axi3_ocm_slave.sv
// Scoreboard bench for axi3_ocm_slave: tasks drive bursts and push expected
// responses from a word-array memory model; negedge monitors pop and compare.
module tb_axi3_ocm_slave;
   localparam logic [31:0] BASE  = 32'hfffc0000;
   localparam int          MW    = 10;
   localparam int          DEPTH = 1 << MW;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, wdata, araddr;
   logic [5:0]  awid, arid;
   logic [3:0]  awlen, arlen, wstrb;
   logic        awvalid, wlast, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [5:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   axi3_ocm_slave #(.base_addr(BASE), .mem_width(MW)) dut (
      .AXI_clk(clk), .rst(rst),
      .AXI_awaddr(awaddr), .AXI_awid(awid), .AXI_awlen(awlen),
      .AXI_awsize(3'b010), .AXI_awburst(2'b01), .AXI_awvalid(awvalid), .AXI_awready(awready),
      .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wlast(wlast), .AXI_wvalid(wvalid), .AXI_wready(wready),
      .AXI_bid(bid), .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
      .AXI_araddr(araddr), .AXI_arid(arid), .AXI_arlen(arlen),
      .AXI_arsize(3'b010), .AXI_arburst(2'b01), .AXI_arvalid(arvalid), .AXI_arready(arready),
      .AXI_rdata(rdata), .AXI_rid(rid), .AXI_rresp(rresp), .AXI_rlast(rlast),
      .AXI_rvalid(rvalid), .AXI_rready(rready)
   );

   typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [5:0] id;} rexp_t;
   typedef struct packed {logic [1:0] resp; logic [5:0] id;} bexp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit [31:0]   mdl [DEPTH];
   rexp_t       rq[$];
   bexp_t       bq[$];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no handshake within cycle budget, expected one (t=%0t)", nm, $time);
   endtask

   function automatic bit inr(input bit [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: compare on handshakes, and check outputs hold while ready is low.
   logic        r_hold = 1'b0, b_hold = 1'b0;
   logic [31:0] p_rdata;
   logic [1:0]  p_rresp, p_bresp;
   logic        p_rlast;
   logic [5:0]  p_bid;

   always @(negedge clk) begin
      rexp_t e;
      if (!rst) begin
         r_hold = 1'b0;
      end else begin
         if (r_hold) chk("r_stable", {rvalid, rlast, rresp, rdata}, {1'b1, p_rlast, p_rresp, p_rdata});
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL r_unexpected: got beat %h, expected none", rdata);
            end else begin
               e = rq.pop_front();
               chk("r_beat", {rdata, rresp, rlast, rid}, e);
            end
         end
         r_hold  = rvalid && !rready;
         p_rdata = rdata; p_rresp = rresp; p_rlast = rlast;
      end
   end

   always @(negedge clk) begin
      bexp_t e;
      if (!rst) begin
         b_hold = 1'b0;
      end else begin
         if (b_hold) chk("b_stable", {bvalid, bresp, bid}, {1'b1, p_bresp, p_bid});
         if (bvalid && bready) begin
            if (bq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL b_unexpected: got bresp %h, expected none", bresp);
            end else begin
               e = bq.pop_front();
               chk("b_resp", {bresp, bid}, e);
            end
         end
         b_hold  = bvalid && !bready;
         p_bresp = bresp; p_bid = bid;
      end
   end

   task automatic do_write(input bit [31:0] a, input logic [5:0] id, input int len,
                           input int bad_last, input int bstall, input bit gaps);
      bit        err = 0;
      bit        hs;
      int        n;
      bit [31:0] ba;
      bit        wl;
      for (int i = 0; i <= len; i++) begin
         ba = a + 32'(4 * i);
         wl = (bad_last >= 0) ? (i == bad_last) : (i == len);
         if (!inr(ba)) err = 1;
         else for (int b = 0; b < 4; b++)
            if (ws[i][b]) mdl[(ba - BASE) >> 2][8*b +: 8] = wd[i][8*b +: 8];
         if (wl != (i == len)) err = 1;
      end
      bq.push_back({err ? 2'b10 : 2'b00, id});

      awaddr = a; awid = id; awlen = 4'(len); awvalid = 1'b1; n = 0;
      do begin @(negedge clk); hs = awready; tick(); n++; end while (!hs && n < 100);
      awvalid = 1'b0;
      if (!hs) begin tmo("aw_handshake"); return; end
      chk("wready_after_aw", wready, 1);

      for (int i = 0; i <= len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
         wdata = wd[i]; wstrb = ws[i];
         wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
         wvalid = 1'b1; n = 0;
         do begin @(negedge clk); hs = wready; tick(); n++; end while (!hs && n < 100);
         if (!hs) begin wvalid = 1'b0; tmo("w_handshake"); return; end
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_after_wlast", bvalid, 1);

      bready = 1'b0;
      for (int i = 0; i < bstall; i++) tick();
      bready = 1'b1; n = 0;
      do begin @(negedge clk); hs = bvalid; tick(); n++; end while (!hs && n < 100);
      bready = 1'b0;
      if (!hs) begin tmo("b_handshake"); return; end
      chk("awready_after_b", awready, 1);
   endtask

   task automatic do_read(input bit [31:0] a, input logic [5:0] id, input int len,
                          input int stall_at, input int stall_n, input int abort_at);
      bit        hs;
      int        n, beats, scnt, last_beat;
      bit [31:0] ba;
      last_beat = (abort_at >= 0) ? abort_at - 1 : len;
      for (int i = 0; i <= last_beat; i++) begin
         ba = a + 32'(4 * i);
         rq.push_back({inr(ba) ? mdl[(ba - BASE) >> 2] : 32'd0,
                       inr(ba) ? 2'b00 : 2'b10, 1'(i == len), id});
      end

      araddr = a; arid = id; arlen = 4'(len); arvalid = 1'b1; n = 0;
      do begin @(negedge clk); hs = arready; tick(); n++; end while (!hs && n < 100);
      arvalid = 1'b0;
      if (!hs) begin tmo("ar_handshake"); return; end
      chk("rvalid_after_ar", rvalid, 1);

      beats = 0; n = 0; scnt = 0;
      while (beats <= len && n < 200) begin
         if (abort_at >= 0 && beats == abort_at) break;
         rready = !(stall_at >= 0 && beats == stall_at && scnt < stall_n);
         @(negedge clk);
         if (rvalid && rready) beats++;
         else if (!rready) scnt++;
         tick(); n++;
      end

      if (abort_at >= 0) begin
         rst = 1'b0;
         #1;
         chk("rvalid_in_reset", {rvalid, rlast, arready}, 3'b000);
         rready = 1'b0;
         tick(); tick();
         rst = 1'b1;
         #1;
         chk("arready_before_edge", arready, 0);
         tick();
         chk("ready_after_release", {arready, awready}, 2'b11);
      end else begin
         rready = 1'b0;
         if (beats <= len) begin tmo("r_beats"); return; end
         chk("r_cycles", n, len + 1 + ((stall_at >= 0) ? stall_n : 0));
         chk("arready_after_r", arready, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1);
   end

   initial begin
      bit [31:0] a;
      int        len, sel;
      rst = 1'b0;
      awaddr = 0; awid = 0; awlen = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      araddr = 0; arid = 0; arlen = 0; arvalid = 0; rready = 0;
      tick(); tick();
      chk("reset_outputs", {awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid},
          58'd0);
      rst = 1'b1;
      #1;
      chk("ready_before_first_edge", {awready, arready}, 2'b00);
      tick();
      chk("ready_after_first_edge", {awready, arready}, 2'b11);

      // Fill the whole window so every later read has a known reference value.
      for (int k = 0; k < DEPTH / 16; k++) begin
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
         do_write(BASE + 32'(64 * k), 6'(k), 15, -1, 0, 0);
      end

      for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hf; end
      do_write(BASE, 6'h2a, 15, -1, 0, 0);
      do_read(BASE, 6'h15, 15, -1, 0, -1);

      wd[0] = 32'h11223344; ws[0] = 4'hf;
      do_write(BASE + 32'd8, 6'h01, 0, -1, 0, 0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      do_write(BASE + 32'd8, 6'h02, 0, -1, 0, 0);
      do_read(BASE + 32'd8, 6'h03, 0, -1, 0, -1);

      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
      do_write(BASE + 32'(4 * (DEPTH - 1)), 6'h04, 3, -1, 0, 0);
      do_read(BASE + 32'(4 * (DEPTH - 1)), 6'h05, 3, -1, 0, -1);

      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      do_write(BASE + 32'd256, 6'h06, 15, -1, 3, 1);
      do_read(BASE + 32'd256, 6'h07, 15, 4, 5, -1);

      do_write(BASE + 32'd512, 6'h08, 3, 1, 0, 0);
      do_read(BASE + 32'd512, 6'h09, 3, -1, 0, -1);

      do_read(BASE, 6'h0a, 15, -1, 0, 7);
      do_read(BASE, 6'h0b, 15, -1, 0, -1);

      for (int t = 0; t < 60; t++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            2:       a = BASE + 32'(4 * $urandom_range(DEPTH - 16, DEPTH - 1));
            default: a = BASE - 32'(4 * $urandom_range(1, 6));
         endcase
         len = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(a, 6'($urandom), len, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1,
                     $urandom_range(0, 2), 1);
         end
         do_read(a, 6'($urandom), len, ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1,
                 $urandom_range(1, 3), -1);
      end

      tick(); tick();
      if (rq.size() != 0 || bq.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: got %0d r / %0d b left, expected 0", rq.size(), bq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
